// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with redirect, stall and flush handling
//
// Fetches one instruction word per request from instruction memory and holds
// it in a single output slot for the decode/control stage.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   PC_STEP   sequential PC increment in bytes
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   imem_req     out  1   instruction-memory read request
//   imem_addr    out  32  byte address of the request
//   imem_ack     in   1   read data valid this cycle
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   redirect_en  in   1   one-cycle redirect pulse
//   redirect_pc  in   32  redirect target
//   stall        in   1   downstream cannot accept the held instruction
//   if_valid     out  1   held instruction is valid
//   if_instr     out  32  held instruction word
//   if_pc        out  32  address of if_instr
//   if_pc4       out  32  if_pc + PC_STEP
//   op           out  6   if_instr[31:26]
//   misalign     out  1   sticky misaligned-redirect flag (IF_ALIGN_CHECK_EN only)
//
// Optional feature macro: IF_ALIGN_CHECK_EN
//   defined   : misaligned redirect target sets misalign and parks in ERROR
//   undefined : redirect target low two bits are cleared when loaded

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [5:0]  op
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_WAIT_SLOT = 2'd1,
    S_FLUSH     = 2'd2,
    S_ERROR     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] flush_pc;     // redirect target held while the old request drains
  logic        pending;      // a request was issued and not yet acknowledged
  logic        slot_free;
  logic        ack_fire;
  logic        redir_bad;
  logic [31:0] redir_target;

  assign slot_free    = !if_valid || !stall;
  assign ack_fire     = imem_req && imem_ack;
  assign redir_target = redirect_pc & ~32'h3;
  assign op           = if_instr[31:26];

`ifdef IF_ALIGN_CHECK_EN
  assign redir_bad = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (redirect_en) begin
          if (redir_bad)
            state_nxt = S_ERROR;
          else if (imem_req && !imem_ack)
            state_nxt = S_FLUSH;
          else
            state_nxt = S_FETCH;
        end else if (!imem_req) begin
          state_nxt = S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        if (redirect_en)
          state_nxt = redir_bad ? S_ERROR : S_FETCH;
        else if (slot_free)
          state_nxt = S_FETCH;
      end
      S_FLUSH: begin
        if (redir_bad)
          state_nxt = S_ERROR;
        else if (imem_ack)
          state_nxt = S_FETCH;
      end
      default: state_nxt = S_ERROR;
    endcase
  end

  // Output logic: an issued request is held until acknowledged, so a pending
  // request keeps imem_req up even if the slot would not otherwise be free.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst_n) begin
      case (state)
        S_FETCH: imem_req = pending || slot_free;
        S_FLUSH: imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  // Datapath: PC, output slot and request bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      flush_pc <= RESET_PC;
      pending  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      if_pc4   <= 32'h0;
    end else begin
      pending <= imem_req && !imem_ack && (state_nxt != S_ERROR);

      if (if_valid && !stall)
        if_valid <= 1'b0;

      if (redirect_en && (state != S_ERROR)) begin
        // Redirect wins over any same-cycle capture.
        if_valid <= 1'b0;
        if (redir_bad) begin
          pc <= pc;
        end else if (state_nxt == S_FLUSH) begin
          flush_pc <= redir_target;
        end else begin
          pc <= redir_target;
        end
      end else if (ack_fire && (state == S_FLUSH)) begin
        // Drained the stale request; its data is dropped.
        pc <= flush_pc;
      end else if (ack_fire && (state == S_FETCH)) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_pc4   <= pc + STEP;
        if_valid <= 1'b1;
        pc       <= pc + STEP;
      end

      if (state == S_ERROR)
        if_valid <= 1'b0;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (redir_bad && (state != S_ERROR)) begin
      misalign <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [5:0]  op;
`ifdef IF_ALIGN_CHECK_EN
  logic        misalign;
  logic        misalign2;
`endif

  // Second instance with a wrapping reset PC
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc42;
  logic [5:0]  op2;

  int lat;
  int wait_cnt;
  logic ack_extra;
  int tests;
  int fails;

  assign imem_ack   = ack_extra || (imem_req && (wait_cnt == lat));
  assign imem_rdata = imem_ack ? (32'h8C01_0004 + imem_addr) : 32'hDEAD_BEEF;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .op(op)
`ifdef IF_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(32'h0000_0013),
    .redirect_en(1'b0), .redirect_pc(32'h0),
    .stall(1'b0),
    .if_valid(valid2), .if_instr(instr2), .if_pc(pc2),
    .if_pc4(pc42), .op(op2)
`ifdef IF_ALIGN_CHECK_EN
    , .misalign(misalign2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n)
      wait_cnt <= 0;
    else
      wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    lat = 0;
    ack_extra = 1'b0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_op", 32'(op), 32'h0);

    // Streaming with combinational ack
    rst_n = 1'b1;
    #1;
    chk("s_req", 32'(imem_req), 32'h1);
    chk("s_addr0", imem_addr, 32'h0);
    tick();
    chk("s_valid", 32'(if_valid), 32'h1);
    chk("s_pc0", if_pc, 32'h0);
    chk("s_instr0", if_instr, 32'h8C01_0004);
    chk("s_op", 32'(op), 32'h23);
    chk("s_pc4_0", if_pc4, 32'h4);
    chk("w_pc0", pc2, 32'hFFFF_FFFC);
    tick();
    chk("s_pc1", if_pc, 32'h4);
    chk("w_pc1", pc2, 32'h0);
    chk("w_pc4", pc42, 32'h4);
    tick();
    chk("s_pc2", if_pc, 32'h8);
    tick();
    chk("s_pc3", if_pc, 32'hC);
    chk("s_instr3", if_instr, 32'h8C01_0010);

    // Stall for three cycles
    stall = 1'b1;
    #1;
    chk("st_req0", 32'(imem_req), 32'h0);
    tick();
    chk("st_pc_a", if_pc, 32'hC);
    chk("st_valid_a", 32'(if_valid), 32'h1);
    chk("st_req1", 32'(imem_req), 32'h0);
    tick();
    tick();
    chk("st_pc_b", if_pc, 32'hC);
    chk("st_instr_b", if_instr, 32'h8C01_0010);
    stall = 1'b0;
    tick();
    chk("st_drop_valid", 32'(if_valid), 32'h0);
    chk("st_req_addr", imem_addr, 32'h10);
    chk("st_req2", 32'(imem_req), 32'h1);
    tick();
    chk("st_pc_next", if_pc, 32'h10);
    chk("st_valid_next", 32'(if_valid), 32'h1);
    tick();
    chk("st_pc_next2", if_pc, 32'h14);

    // Slow memory, redirect while request outstanding
    lat = 3;
    #1;
    chk("fl_addr0", imem_addr, 32'h18);
    tick();
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("fl_hold_req", 32'(imem_req), 32'h1);
    chk("fl_hold_addr", imem_addr, 32'h18);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("fl_ack", 32'(imem_ack), 32'h1);
    chk("fl_keep_addr", imem_addr, 32'h18);
    tick();
    chk("fl_discard", 32'(if_valid), 32'h0);
    lat = 0;
    #1;
    chk("fl_new_addr", imem_addr, 32'h40);
    tick();
    chk("fl_valid", 32'(if_valid), 32'h1);
    chk("fl_pc", if_pc, 32'h40);
    chk("fl_instr", if_instr, 32'h8C01_0044);

    // Redirect coincident with ack
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    chk("ra_novalid", 32'(if_valid), 32'h0);
    #1;
    chk("ra_addr", imem_addr, 32'h100);
    tick();
    chk("ra_pc", if_pc, 32'h100);
    chk("ra_pc4", if_pc4, 32'h104);

    // Misaligned redirect
    redirect_en = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_en = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    chk("ma_flag", 32'(misalign), 32'h1);
    chk("ma_req", 32'(imem_req), 32'h0);
    redirect_en = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_en = 1'b0;
    tick();
    chk("ma_req_held", 32'(imem_req), 32'h0);
    chk("ma_valid", 32'(if_valid), 32'h0);
    chk("ma_sticky", 32'(misalign), 32'h1);
`else
    chk("ma_addr", imem_addr, 32'h40);
    tick();
    chk("ma_pc", if_pc, 32'h40);
`endif

    // Reset abandons an outstanding request; late ack is ignored
    lat = 50;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rr_req", 32'(imem_req), 32'h0);
    tick();
    ack_extra = 1'b1;
    tick();
    chk("rr_late_valid", 32'(if_valid), 32'h0);
    chk("rr_late_pc", if_pc, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
    chk("rr_misalign", 32'(misalign), 32'h0);
`endif
    ack_extra = 1'b0;
    lat = 0;
    rst_n = 1'b1;
    #1;
    chk("rr_addr", imem_addr, 32'h0);
    tick();
    chk("rr_pc", if_pc, 32'h0);
    chk("rr_instr", if_instr, 32'h8C01_0004);
    tick();
    chk("rr_pc1", if_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
